d_latch_cell: RTL and testbench

D_LATCH_CELL -- requirements
Module: d_latch

---
 rtl/d_latch_pkg.sv | 23 ++
 rtl/d_latch_bit.sv | 33 +++
 rtl/d_latch_cell.sv | 42 ++++
 tb/tb_d_latch_cell.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_latch_pkg.sv
// Shared constants and output-mode encoding for the clocked D-latch emulation.
package d_latch_pkg;

  localparam int MIN_WIDTH     = 1;
  localparam int MAX_WIDTH     = 64;
  localparam int DEFAULT_WIDTH = 1;
  localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

  // Output mux select; reset overrides enable, enable selects the bypass.
  typedef enum logic [1:0] {
    MODE_RESET       = 2'd0,
    MODE_TRANSPARENT = 2'd1,
    MODE_HOLD        = 2'd2
  } mode_t;

  // Reset has priority over enable.
  function automatic mode_t decode_mode(input logic rst, input logic en);
    if (rst)     return MODE_RESET;
    else if (en) return MODE_TRANSPARENT;
    else         return MODE_HOLD;
  endfunction

endpackage

// File: rtl/d_latch_bit.sv
// One bit of the emulated latch: storage flop, transparent bypass mux and
// inverted output. The mode is decoded once at the top and shared by all bits.
module d_latch_bit
  import d_latch_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk_i,
  input  mode_t mode_i,
  input  logic  d_i,
  output logic  q_o,
  output logic  q_inv_o
);

  logic stored_q;

  // Storage: reset loads RESET_BIT, transparency captures d_i, hold keeps value.
  always_ff @(posedge clk_i) begin
    case (mode_i)
      MODE_RESET:       stored_q <= RESET_BIT;
      MODE_TRANSPARENT: stored_q <= d_i;
      default:          stored_q <= stored_q;
    endcase
  end

  // Output: bypass d_i only while transparent; reset and hold show the flop.
  always_comb begin
    q_o     = stored_q;
    if (mode_i == MODE_TRANSPARENT) q_o = d_i;
    q_inv_o = ~q_o;
  end

endmodule

// File: rtl/d_latch_cell.sv
// Level-sensitive D latch emulated with a clocked register per bit plus a
// combinational bypass, so no real latch or loop is ever inferred. Known
// limitation: on enable fall the held value is the d_i seen at the last rising
// clock edge with enable high, not the value just before enable dropped.
module d_latch_cell
  import d_latch_pkg::*;
#(
  parameter int                WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             e_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_inv_o
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("d_latch_cell: WIDTH=%0d outside legal range 1..64", WIDTH);
  end

  mode_t mode;

  // Decode the output mode once and fan it out to every bit.
  always_comb begin
    mode = decode_mode(rst_i, e_i);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_bit #(
      .RESET_BIT (RESET_VAL[i])
    ) u_bit (
      .clk_i   (clk_i),
      .mode_i  (mode),
      .d_i     (d_i[i]),
      .q_o     (q_o[i]),
      .q_inv_o (q_inv_o[i])
    );
  end

endmodule

// File: tb/tb_d_latch_cell.sv
// Bench for d_latch_cell: a 1-bit instance with zero reset value and an 8-bit
// instance with reset value 0xA5. Directed scenarios push constant expectations,
// random phases push values from a behavioural latch model; a monitor process
// pops the expectation queues and compares against the DUT outputs.
module tb_d_latch_cell;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, e1 = 1'b1, d1 = 1'b1;
  logic       rst8 = 1'b1, e8 = 1'b1;
  logic [7:0] d8   = 8'hFF;
  logic       q1, qi1;
  logic [7:0] q8, qi8;

  d_latch_cell dut1 (
    .clk_i   (clk),
    .rst_i   (rst1),
    .d_i     (d1),
    .e_i     (e1),
    .q_o     (q1),
    .q_inv_o (qi1)
  );

  d_latch_cell #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) dut8 (
    .clk_i   (clk),
    .rst_i   (rst8),
    .d_i     (d8),
    .e_i     (e8),
    .q_o     (q8),
    .q_inv_o (qi8)
  );

  // ---------------- reference model ----------------
  // A latch remembers the last value it saw while open at a clock edge;
  // reset forces the reset value; outputs are unknown until the first reset.
  logic       m1_stored;
  logic [7:0] m8_stored;
  bit         m1_valid = 1'b0, m8_valid = 1'b0;

  always @(posedge clk) begin
    if (rst1) begin m1_stored <= 1'b0;  m1_valid <= 1'b1; end
    else if (e1) m1_stored <= d1;
    if (rst8) begin m8_stored <= 8'hA5; m8_valid <= 1'b1; end
    else if (e8) m8_stored <= d8;
  end

  // ---------------- scoreboard ----------------
  logic [1:0]  exp1_q[$];
  logic [15:0] exp8_q[$];
  string       lbl1_q[$];
  string       lbl8_q[$];
  int          check_tick = 0;
  int          checks = 0;
  int          errors = 0;

  // Monitor: whenever the driver signals a sample point, drain and compare.
  initial begin
    forever begin
      @(check_tick);
      while (exp1_q.size() > 0) begin
        logic [1:0] e;
        string      nm;
        e  = exp1_q.pop_front();
        nm = lbl1_q.pop_front();
        checks++;
        if ({q1, qi1} !== e) begin
          errors++;
          $display("FAIL %s w1: got q=%b q_inv=%b want q=%b q_inv=%b @%0t",
                   nm, q1, qi1, e[1], e[0], $time);
        end
      end
      while (exp8_q.size() > 0) begin
        logic [15:0] e;
        string       nm;
        e  = exp8_q.pop_front();
        nm = lbl8_q.pop_front();
        checks++;
        if ({q8, qi8} !== e) begin
          errors++;
          $display("FAIL %s w8: got q=%h q_inv=%h want q=%h q_inv=%h @%0t",
                   nm, q8, qi8, e[15:8], e[7:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample();
    check_tick++;
    #1;
  endtask

  task automatic exp1(input logic q, input string nm);
    exp1_q.push_back({q, ~q});
    lbl1_q.push_back(nm);
    sample();
  endtask

  task automatic exp8(input logic [7:0] q, input string nm);
    exp8_q.push_back({q, ~q});
    lbl8_q.push_back(nm);
    sample();
  endtask

  task automatic exp_model(input string nm);
    logic       x1;
    logic [7:0] x8;
    if (m1_valid) begin
      x1 = (!rst1 && e1) ? d1 : m1_stored;
      exp1_q.push_back({x1, ~x1});
      lbl1_q.push_back(nm);
    end
    if (m8_valid) begin
      x8 = (!rst8 && e8) ? d8 : m8_stored;
      exp8_q.push_back({x8, ~x8});
      lbl8_q.push_back(nm);
    end
    sample();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two clocks with e=1, d=1: output stays at reset value.
    @(posedge clk); #1; exp1(1'b0, "reset_edge1");
    @(negedge clk); #1; exp1(1'b0, "reset_mid");
    @(posedge clk); #1; exp1(1'b0, "reset_edge2");

    // Transparency: d follows with zero latency.
    @(negedge clk); rst1 = 1'b0; e1 = 1'b1; d1 = 1'b0;
    #1; exp1(1'b0, "transp_d0");
    @(posedge clk);
    @(negedge clk); d1 = 1'b1;
    #1; exp1(1'b1, "transp_d1");
    @(posedge clk);

    // Hold: d toggles, q stays at the captured 1.
    @(negedge clk); e1 = 1'b0; d1 = 1'b0;
    #1; exp1(1'b1, "hold_d0");
    @(posedge clk); #1; exp1(1'b1, "hold_edge");
    @(negedge clk); d1 = 1'b1;
    #1; exp1(1'b1, "hold_d1");
    @(negedge clk); d1 = 1'b0;
    #1; exp1(1'b1, "hold_d0b");

    // Reopen with d=0 over one edge, then hold 0 through d toggles.
    @(negedge clk); e1 = 1'b1; d1 = 1'b0;
    #1; exp1(1'b0, "reopen_d0");
    @(posedge clk); #1; exp1(1'b0, "reopen_edge");
    @(negedge clk); e1 = 1'b0; d1 = 1'b1;
    #1; exp1(1'b0, "rehold_d1");
    @(negedge clk); d1 = 1'b0;
    #1; exp1(1'b0, "rehold_d0");

    // Enable fall keeps the last edge-captured value, not the late d change.
    @(negedge clk); e1 = 1'b1; d1 = 1'b1;
    #1; exp1(1'b1, "efall_open");
    @(negedge clk); d1 = 1'b0;
    #1; exp1(1'b0, "efall_late_d");
    #1; e1 = 1'b0;
    #1; exp1(1'b1, "efall_held");

    // Reset pulse mid-transparency.
    @(negedge clk); e1 = 1'b1; d1 = 1'b1;
    #1; exp1(1'b1, "rstmid_open");
    @(negedge clk); rst1 = 1'b1;
    #1; exp1(1'b1, "rstmid_pre_edge");
    @(posedge clk); #1; exp1(1'b0, "rstmid_pulse");
    @(negedge clk); rst1 = 1'b0;
    #1; exp1(1'b1, "rstmid_release");

    // Simultaneous e and d rise shows new d at once.
    @(negedge clk); e1 = 1'b0; d1 = 1'b0;
    #1; exp1(1'b1, "simul_hold");
    @(negedge clk); #2; e1 = 1'b1; d1 = 1'b0;
    #1; exp1(1'b0, "simul_rise0");
    @(negedge clk); e1 = 1'b0;
    @(negedge clk); #2; e1 = 1'b1; d1 = 1'b1;
    #1; exp1(1'b1, "simul_rise1");

    // 8-bit instance: reset value 0xA5, transparency, hold.
    @(posedge clk); #1; exp8(8'hA5, "w8_reset");
    @(negedge clk); rst8 = 1'b0; e8 = 1'b1; d8 = 8'h3C;
    #1; exp8(8'h3C, "w8_transp");
    @(posedge clk); #1; exp8(8'h3C, "w8_edge");
    @(negedge clk); e8 = 1'b0; d8 = 8'hFF;
    #1; exp8(8'h3C, "w8_hold");
    @(posedge clk); #1; exp8(8'h3C, "w8_hold_edge");

    // Randomized phase against the behavioural model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst1 = ($urandom_range(0, 7) == 0);
      e1   = $urandom_range(0, 1);
      d1   = $urandom_range(0, 1);
      rst8 = ($urandom_range(0, 7) == 0);
      e8   = $urandom_range(0, 1);
      d8   = 8'($urandom_range(0, 255));
      #1; exp_model("rand_edge");
      if ($urandom_range(0, 1) == 1) begin
        #1;
        d1 = $urandom_range(0, 1);
        d8 = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) begin
          e1 = ~e1;
          e8 = ~e8;
        end
        #1; exp_model("rand_mid");
      end
    end

    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
